// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target responder with pointer-based register-file access
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h48,
  parameter int         FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic       reg_wr_en,
  output logic [7:0] reg_wr_data,
  input  logic [7:0] reg_rd_data,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det
);

  localparam int              FCW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FCW-1:0]  FCNT_LAST = FCW'(FILTER_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  // Line index 0 is SCL, index 1 is SDA. Idle bus level is high on both.
  logic [1:0]     sync1_q, sync2_q, filt_q, filt_d, filt_prev_q;
  logic [FCW-1:0] fcnt_q [2];
  logic [FCW-1:0] fcnt_d [2];

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       full_q, full_d;        // 8 bits received, waiting for the SCL fall to act
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;            // tx_q[7] is the bit currently on the bus
  logic       rw_q, rw_d;
  logic       ack_q, ack_d;          // master ACK sampled during RDATA_ACK
  logic       inc_q, inc_d;          // pointer bump one clock after a write strobe
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       wr_en_q, wr_en_d;
  logic       busy_q, busy_d;
  logic       start_det_q, start_det_d;
  logic       stop_det_q, stop_det_d;

  // Synchronize both pads and hold the filtered levels plus their previous values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      filt_q      <= 2'b11;
      filt_prev_q <= 2'b11;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
    end else begin
      sync1_q     <= {sda_in, scl_in};
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= fcnt_d[i];
    end
  end

  // Accept a new level only after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      fcnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FCNT_LAST) filt_d[i] = sync2_q[i];
        else                        fcnt_d[i] = fcnt_q[i] + FCW'(1);
      end
    end
  end

  logic sda_f, scl_rise, scl_fall, sda_rise, sda_fall, start_cond, stop_cond;
  assign sda_f      = filt_q[1];
  assign scl_rise   =  filt_q[0] & ~filt_prev_q[0];
  assign scl_fall   = ~filt_q[0] &  filt_prev_q[0];
  assign sda_rise   =  filt_q[1] & ~filt_prev_q[1];
  assign sda_fall   = ~filt_q[1] &  filt_prev_q[1];
  assign start_cond = sda_fall & filt_q[0] & filt_prev_q[0];
  assign stop_cond  = sda_rise & filt_q[0] & filt_prev_q[0];

  // Protocol state and register-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      full_q      <= 1'b0;
      rx_q        <= 8'd0;
      tx_q        <= 8'd0;
      rw_q        <= 1'b0;
      ack_q       <= 1'b0;
      inc_q       <= 1'b0;
      sda_oe_q    <= 1'b0;
      reg_addr_q  <= 8'd0;
      wr_data_q   <= 8'd0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      full_q      <= full_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      ack_q       <= ack_d;
      inc_q       <= inc_d;
      sda_oe_q    <= sda_oe_d;
      reg_addr_q  <= reg_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      busy_q      <= busy_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
    end
  end

  // Next-state logic; SDA is only ever changed on a detected SCL fall.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    full_d      = full_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    ack_d       = ack_q;
    inc_d       = 1'b0;
    sda_oe_d    = sda_oe_q;
    reg_addr_d  = reg_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    busy_d      = busy_q;
    start_det_d = 1'b0;
    stop_det_d  = 1'b0;

    if (inc_q) reg_addr_d = reg_addr_q + 8'd1;

    if (start_cond) begin
      // Pointer is kept so a write-pointer / restart / read sequence works.
      start_det_d = 1'b1;
      bit_cnt_d   = 3'd0;
      full_d      = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      state_d     = ADDR;
    end else if (stop_cond) begin
      stop_det_d = 1'b1;
      bit_cnt_d  = 3'd0;
      full_d     = 1'b0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      state_d    = IDLE;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise && !full_q) begin
            rx_d      = {rx_q[6:0], sda_f};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) full_d = 1'b1;
          end else if (scl_fall && full_q) begin
            full_d    = 1'b0;
            bit_cnt_d = 3'd0;
            if (state_q == ADDR) begin
              if (rx_q[7:1] == TARGET_ADDR) begin
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
                rw_d     = rx_q[0];
                state_d  = ADDR_ACK;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = IGNORE;
              end
            end else if (state_q == PTR) begin
              reg_addr_d = rx_q;
              sda_oe_d   = 1'b1;
              state_d    = PTR_ACK;
            end else begin
              wr_data_d = rx_q;
              wr_en_d   = 1'b1;
              inc_d     = 1'b1;
              sda_oe_d  = 1'b1;
              state_d   = WDATA_ACK;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 3'd0;
            if (rw_q) begin
              tx_d     = reg_rd_data;
              sda_oe_d = ~reg_rd_data[7];
              state_d  = RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = PTR;
            end
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = WDATA;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = RDATA_ACK;
            end else begin
              tx_d      = {tx_q[6:0], 1'b0};
              sda_oe_d  = ~tx_q[6];
              bit_cnt_d = bit_cnt_q + 3'd1;
              // Last bit of the byte is now on the bus: advance for the next byte.
              if (bit_cnt_q == 3'd6) reg_addr_d = reg_addr_q + 8'd1;
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            ack_d = ~sda_f;
          end else if (scl_fall) begin
            if (ack_q) begin
              tx_d      = reg_rd_data;
              sda_oe_d  = ~reg_rd_data[7];
              bit_cnt_d = 3'd0;
              state_d   = RDATA;
            end else begin
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
              state_d  = IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe      = sda_oe_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_wr_data = wr_data_q;
  assign busy        = busy_q;
  assign start_det   = start_det_q;
  assign stop_det    = stop_det_q;

endmodule
